q_pair_monitor: RTL and testbench

Synthesizable reader and checker for the dual-phase `q`/`q1` register pair driven by the procedural writer block. The writer updates `q` from `d1` on the rising phase and `q1` with `!d1` on the falling phase. This block samples the pair on `posedge mclk` and checks two rules after `d1` has settled:
- `q != d` (property r4);
- `q1 == !q` (complement).

It counts violations and exposes a sticky error with a req/ack clear handshake. It sits beside the writer in the assertion test harness as its RTL observer.

---
 rtl/q_pair_monitor_pkg.sv | 26 ++
 rtl/qpm_sat_counter.sv | 38 +++
 rtl/q_pair_monitor.sv | 184 ++++++++++++++++++
 tb/tb_q_pair_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/q_pair_monitor_pkg.sv
// -----------------------------------------------------------------------------
// q_pair_monitor_pkg
// Shared types and constants for the q/q1 register-pair monitor.
//   qpm_state_t     : monitor FSM encoding (IDLE=0, ARM=1, CHECK=2, FAULT=3)
//   QPM_SETTLE_W    : width of the settle counter
//   qpm_settle_last : last settle-counter value spent in ARM before CHECK
// -----------------------------------------------------------------------------
package q_pair_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        FAULT = 2'd3
    } qpm_state_t;

    localparam int QPM_SETTLE_W = 4;

    // A settle time of 0 behaves as 1, so ARM always lasts at least one cycle.
    function automatic logic [QPM_SETTLE_W-1:0] qpm_settle_last(input int settle_cyc);
        int eff;
        eff = (settle_cyc < 1) ? 1 : settle_cyc;
        return QPM_SETTLE_W'(eff - 1);
    endfunction

endpackage

// File: rtl/qpm_sat_counter.sv
// -----------------------------------------------------------------------------
// qpm_sat_counter
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Ports:
//   mclk  in  : clock
//   rst_n in  : synchronous active-low reset
//   clear in  : zero the count (priority over inc)
//   inc   in  : increment by one unless saturated
//   count out : registered count, W bits
// -----------------------------------------------------------------------------
module qpm_sat_counter #(
    parameter int W = 8
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clear wins, then saturating increment.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/q_pair_monitor.sv
// -----------------------------------------------------------------------------
// q_pair_monitor
// RTL observer for the dual-phase q/q1 writer pair. Samples the pins every
// edge, waits for d1 to settle, then checks q != d and q1 == !q each cycle.
// Violations pulse viol, bump a saturating count and set a sticky error that
// is cleared by a clr_req/clr_ack level handshake.
// Optional build macro: Q_PAIR_MONITOR_SVA_EN compiles in concurrent
// assertions for both pair rules and the clear handshake; logic is unchanged.
// Ports:
//   mclk, rst_n (sync, active-low), en, d, d1, q, q1, clr_req  : inputs
//   clr_ack, viol, sticky_err, viol_cnt[CNT_W], chk_cnt[CNT_W],
//   state_o[2]                                                 : outputs
// -----------------------------------------------------------------------------
module q_pair_monitor
    import q_pair_monitor_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d,
    input  logic             d1,
    input  logic             q,
    input  logic             q1,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             viol,
    output logic             sticky_err,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state_o
);

    localparam logic [QPM_SETTLE_W-1:0] SETTLE_LAST = qpm_settle_last(SETTLE_CYC);

    logic                    s_d_r, s_d1_r, s_d1_prev_r, s_q_r, s_q1_r;
    qpm_state_t              state_r, state_nxt_s;
    logic [QPM_SETTLE_W-1:0] settle_cnt_r, settle_nxt_s;
    logic                    clr_ack_r, viol_r, sticky_r;
    logic                    d1_chg_s, check_s, viol_s, clr_fire_s, viol_hit_s;

    // Input sample stage; s_d1_prev_r lets us spot a d1 change.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            s_d_r       <= 1'b0;
            s_d1_r      <= 1'b0;
            s_d1_prev_r <= 1'b0;
            s_q_r       <= 1'b0;
            s_q1_r      <= 1'b0;
        end else begin
            s_d_r       <= d;
            s_d1_r      <= d1;
            s_d1_prev_r <= s_d1_r;
            s_q_r       <= q;
            s_q1_r      <= q1;
        end
    end

    // Rule evaluation; a clear on the same edge suppresses the violation.
    always_comb begin
        d1_chg_s   = (s_d1_r != s_d1_prev_r);
        check_s    = (state_r == CHECK);
        viol_s     = check_s && ((s_q_r == s_d_r) || (s_q1_r == s_q_r));
        clr_fire_s = clr_req && !clr_ack_r;
        viol_hit_s = viol_s && !clr_fire_s;
    end

    // FSM next state and settle counter.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_cnt_r;
        case (state_r)
            IDLE: begin
                settle_nxt_s = '0;
                if (en) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM: begin
                if (!en) begin
                    state_nxt_s = IDLE;
                end else if (d1_chg_s) begin
                    // d1 moved again: restart the settle window.
                    state_nxt_s  = ARM;
                    settle_nxt_s = '0;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = CHECK;
                end else begin
                    settle_nxt_s = settle_cnt_r + QPM_SETTLE_W'(1);
                end
            end
            CHECK: begin
                if (STOP_ON_ERR && viol_hit_s) begin
                    state_nxt_s = FAULT;
                end else if (!en) begin
                    state_nxt_s = IDLE;
                end else if (d1_chg_s) begin
                    state_nxt_s  = ARM;
                    settle_nxt_s = '0;
                end else begin
                    state_nxt_s = CHECK;
                end
            end
            FAULT: begin
                if (clr_fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FAULT;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                settle_nxt_s = '0;
            end
        endcase
    end

    // State, violation pulse, sticky flag and clear acknowledge registers.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            settle_cnt_r <= '0;
            viol_r       <= 1'b0;
            sticky_r     <= 1'b0;
            clr_ack_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_nxt_s;
            viol_r       <= viol_hit_s;
            if (clr_fire_s) begin
                sticky_r <= 1'b0;
            end else if (viol_hit_s) begin
                sticky_r <= 1'b1;
            end else begin
                sticky_r <= sticky_r;
            end
            // Ack holds while req stays high, so a held req clears only once.
            if (clr_fire_s) begin
                clr_ack_r <= 1'b1;
            end else if (!clr_req) begin
                clr_ack_r <= 1'b0;
            end else begin
                clr_ack_r <= clr_ack_r;
            end
        end
    end

    qpm_sat_counter #(.W(CNT_W)) u_viol_cnt (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clear (clr_fire_s),
        .inc   (viol_hit_s),
        .count (viol_cnt)
    );

    qpm_sat_counter #(.W(CNT_W)) u_chk_cnt (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clear (clr_fire_s),
        .inc   (check_s),
        .count (chk_cnt)
    );

    assign clr_ack    = clr_ack_r;
    assign viol       = viol_r;
    assign sticky_err = sticky_r;
    assign state_o    = state_r;

`ifdef Q_PAIR_MONITOR_SVA_EN
    a_r4: assert property (@(posedge mclk) disable iff (!rst_n || state_o != CHECK)
        s_q_r != s_d_r);
    a_compl: assert property (@(posedge mclk) disable iff (!rst_n || state_o != CHECK)
        s_q1_r == !s_q_r);
    a_clr_ack: assert property (@(posedge mclk) disable iff (!rst_n)
        (clr_req && !clr_ack) |=> clr_ack);
`else
`endif

endmodule

// File: tb/tb_q_pair_monitor.sv
// -----------------------------------------------------------------------------
// tb_q_pair_monitor
// Directed bench for q_pair_monitor. Three instances share one stimulus:
//   u_a : defaults
//   u_b : STOP_ON_ERR=1
//   u_c : CNT_W=2
// Outputs are sampled 1 time unit after each rising edge.
// Timeline comments count edges E0.. from reset release.
// -----------------------------------------------------------------------------
module tb_q_pair_monitor;

    logic mclk = 1'b0;
    logic rst_n, en, d, d1, q, q1, clr_req;

    logic       clr_ack_a, viol_a, sticky_a;
    logic [7:0] viol_cnt_a, chk_cnt_a;
    logic [1:0] state_a;
    logic       clr_ack_b, viol_b, sticky_b;
    logic [7:0] viol_cnt_b, chk_cnt_b;
    logic [1:0] state_b;
    logic       clr_ack_c, viol_c, sticky_c;
    logic [1:0] viol_cnt_c, chk_cnt_c;
    logic [1:0] state_c;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 mclk = ~mclk;

    q_pair_monitor u_a (
        .mclk(mclk), .rst_n(rst_n), .en(en), .d(d), .d1(d1), .q(q), .q1(q1),
        .clr_req(clr_req), .clr_ack(clr_ack_a), .viol(viol_a), .sticky_err(sticky_a),
        .viol_cnt(viol_cnt_a), .chk_cnt(chk_cnt_a), .state_o(state_a)
    );

    q_pair_monitor #(.STOP_ON_ERR(1'b1)) u_b (
        .mclk(mclk), .rst_n(rst_n), .en(en), .d(d), .d1(d1), .q(q), .q1(q1),
        .clr_req(clr_req), .clr_ack(clr_ack_b), .viol(viol_b), .sticky_err(sticky_b),
        .viol_cnt(viol_cnt_b), .chk_cnt(chk_cnt_b), .state_o(state_b)
    );

    q_pair_monitor #(.CNT_W(2)) u_c (
        .mclk(mclk), .rst_n(rst_n), .en(en), .d(d), .d1(d1), .q(q), .q1(q1),
        .clr_req(clr_req), .clr_ack(clr_ack_c), .viol(viol_c), .sticky_err(sticky_c),
        .viol_cnt(viol_cnt_c), .chk_cnt(chk_cnt_c), .state_o(state_c)
    );

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with every input high.
        rst_n = 1'b0; en = 1'b1; d = 1'b1; d1 = 1'b1; q = 1'b1; q1 = 1'b1; clr_req = 1'b0;
        repeat (3) tick();
        chk("rst_state",    state_a,    0);
        chk("rst_viol",     viol_a,     0);
        chk("rst_sticky",   sticky_a,   0);
        chk("rst_viol_cnt", viol_cnt_a, 0);
        chk("rst_chk_cnt",  chk_cnt_a,  0);
        chk("rst_clr_ack",  clr_ack_a,  0);
        chk("rst_state_b",  state_b,    0);

        // E0: IDLE->ARM. Sampled d1 goes 0->1 here, which restarts the settle
        // window once at E1, so ARM lasts E0..E2 and CHECK starts at E3.
        rst_n = 1'b1;
        tick();
        chk("arm_e0", state_a, 1);
        d = 1'b0; q = 1'b1; q1 = 1'b0;
        tick();
        chk("arm_e1", state_a, 1);
        tick();
        chk("arm_e2", state_a, 1);
        tick();
        chk("check_e3", state_a, 2);
        chk("check_e3_cnt", chk_cnt_a, 0);

        // Correct pair for 10 checked cycles (E4..E13).
        repeat (10) tick();
        chk("good_chk_cnt",  chk_cnt_a,  10);
        chk("good_viol_cnt", viol_cnt_a, 0);
        chk("good_viol",     viol_a,     0);
        chk("good_sticky",   sticky_a,   0);
        chk("good_state",    state_a,    2);
        chk("good_state_b",  state_b,    2);

        // q == d sampled at E14..E16 -> viol visible E15..E17.
        d = 1'b1;
        tick();
        chk("v_e14_viol", viol_a, 0);
        tick();
        chk("v_e15_viol",     viol_a,     1);
        chk("v_e15_cnt",      viol_cnt_a, 1);
        chk("v_e15_sticky",   sticky_a,   1);
        chk("stop_state",     state_b,    3);
        chk("stop_viol_cnt",  viol_cnt_b, 1);
        tick();
        chk("v_e16_viol", viol_a,     1);
        chk("v_e16_cnt",  viol_cnt_a, 2);
        d = 1'b0;
        tick();
        chk("v_e17_viol", viol_a,     1);
        chk("v_e17_cnt",  viol_cnt_a, 3);
        tick();
        chk("v_e18_viol",     viol_a,     0);
        chk("v_e18_cnt",      viol_cnt_a, 3);
        chk("v_e18_chk",      chk_cnt_a,  15);
        chk("v_e18_sticky",   sticky_a,   1);
        chk("sat_viol_e18",   viol_cnt_c, 3);
        chk("sat_chk_e18",    chk_cnt_c,  3);
        chk("stop_hold",      state_b,    3);
        chk("stop_hold_cnt",  viol_cnt_b, 1);
        chk("stop_chk_cnt",   chk_cnt_b,  12);

        // Four more wrong samples E19..E22; three counted by E22.
        d = 1'b1;
        repeat (4) tick();
        chk("v_e22_cnt",  viol_cnt_a, 6);
        chk("v_e22_viol", viol_a,     1);
        chk("v_e22_chk",  chk_cnt_a,  19);
        chk("sat_viol",   viol_cnt_c, 3);

        // Clear on the same edge as a pending violation (E23): clear wins.
        clr_req = 1'b1; d = 1'b0;
        tick();
        chk("clr_viol",     viol_a,     0);
        chk("clr_viol_cnt", viol_cnt_a, 0);
        chk("clr_sticky",   sticky_a,   0);
        chk("clr_ack_up",   clr_ack_a,  1);
        chk("clr_chk_cnt",  chk_cnt_a,  0);
        chk("clr_fault_b",  state_b,    0);
        chk("clr_sat",      viol_cnt_c, 0);
        tick();
        tick();
        chk("clr_hold_ack", clr_ack_a, 1);
        chk("clr_no_again", chk_cnt_a, 2);
        clr_req = 1'b0;
        tick();
        chk("clr_ack_down", clr_ack_a, 0);
        chk("clr_after",    chk_cnt_a, 3);

        // Disable from CHECK: one last check, then IDLE.
        en = 1'b0;
        tick();
        chk("dis_state", state_a,   0);
        chk("dis_chk",   chk_cnt_a, 4);

        // Wrong pair while d1 toggles every cycle: never leaves ARM.
        en = 1'b1; d = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d1 = ~d1;
            tick();
            chk("tog_state", state_a,    1);
            chk("tog_viol",  viol_cnt_a, 0);
        end
        chk("tog_chk", chk_cnt_a, 4);

        // d1 held: one restart, two ARM cycles, then CHECK flags the wrong pair.
        tick();
        chk("settle_1", state_a, 1);
        tick();
        chk("settle_2", state_a, 1);
        tick();
        chk("settle_chk", state_a, 2);
        tick();
        chk("settle_viol",   viol_a,     1);
        chk("settle_cnt",    viol_cnt_a, 1);
        chk("settle_sticky", sticky_a,   1);

        // Disable: counters and sticky retained.
        en = 1'b0;
        tick();
        chk("en0_viol",  viol_a,     1);
        chk("en0_cnt",   viol_cnt_a, 2);
        chk("en0_state", state_a,    0);
        tick();
        chk("ret_viol",   viol_a,     0);
        chk("ret_cnt",    viol_cnt_a, 2);
        chk("ret_sticky", sticky_a,   1);

        // Reset in the middle of a handshake.
        clr_req = 1'b1;
        tick();
        chk("mid_ack", clr_ack_a, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ack",   clr_ack_a,  0);
        chk("mid_rst_state", state_a,    0);
        chk("mid_rst_cnt",   chk_cnt_a,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
